// File: rtl/threshold_sample_fifo.sv
// threshold_sample_fifo
//   Frame-oriented delay-line FIFO for the 8-channel threshold integrator.
//   It holds DATA_WIDTH-bit per-channel sample sums, FRAME_DEPTH frames of
//   8 words each. Every word is tagged with a channel index. Status is
//   reported per frame. A sticky fault freezes the FIFO on overflow,
//   underflow or a misaligned frame pop, so a mis-sized integration window
//   cannot silently corrupt the running totals.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   enable             run enable; low flushes the FIFO and returns to IDLE
//   push_valid/data    write one word, tagged with push_channel
//   push_channel       channel index of the next push (wr_ptr[2:0])
//   pop_req            read one word
//   pop_data/valid     registered read word, strobe 1 cycle after the pop
//   pop_channel        channel index of pop_data
//   frame_available    >= 8 words stored
//   full / empty       word count == FRAME_DEPTH*8 / == 0
//   fault              sticky overflow/underflow/misalignment flag
//
// Optional feature macro: THRESHOLD_SAMPLE_FIFO_FRAME_COUNT_EN
//   When it is defined, the block adds two registered outputs:
//     frame_count  the number of whole frames stored
//     high_water   the peak frame_count since the block left IDLE
module threshold_sample_fifo #(
  parameter int FRAME_DEPTH = 64,
  parameter int DATA_WIDTH  = 36
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [2:0]            push_channel,
  input  logic                  pop_req,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic [2:0]            pop_channel,
  output logic                  frame_available,
  output logic                  full,
  output logic                  empty,
`ifdef THRESHOLD_SAMPLE_FIFO_FRAME_COUNT_EN
  output logic [$clog2(FRAME_DEPTH):0] frame_count,
  output logic [$clog2(FRAME_DEPTH):0] high_water,
`endif
  output logic                  fault
);
  localparam int WORDS = FRAME_DEPTH * 8;
  localparam int AW    = $clog2(WORDS);
  // WORDS is a power of two, so a full count is just the MSB of the count.
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FLT} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic push_try, pop_try, overflow, underflow, misalign, evt;
  logic push_ok, pop_ok, clr;

  // All status decisions use the registered count from before the edge.
  // Any fault event cancels the whole cycle: no write and no read.
  always_comb begin
    push_try  = (state == RUN) && enable && push_valid;
    pop_try   = (state == RUN) && enable && pop_req;
    overflow  = push_try && full;
    underflow = pop_try && empty;
    // A pop that starts a frame must have a complete frame behind it.
    misalign  = pop_try && !empty && (rd_ptr[2:0] == 3'd0) && (count[AW:3] == '0);
    evt       = overflow || underflow || misalign;
    push_ok   = push_try && !evt;
    pop_ok    = pop_try && !evt;
    clr       = (state == IDLE) || !enable;
    count_nxt = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
  end

  // FSM: state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
               else if (evt) state_nxt = FLT;
      FLT:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    fault        = (state == FLT);
    push_channel = wr_ptr[2:0];
  end

  // Storage array. It has no reset, because its contents after reset are
  // never read before they are written.
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= push_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      pop_data        <= '0;
      pop_valid       <= 1'b0;
      pop_channel     <= 3'd0;
      empty           <= 1'b1;
      full            <= 1'b0;
      frame_available <= 1'b0;
    end else if (clr) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      pop_valid       <= 1'b0;
      empty           <= 1'b1;
      full            <= 1'b0;
      frame_available <= 1'b0;
    end else begin
      // In FAULT, push_ok and pop_ok are both low, so everything holds.
      pop_valid <= pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        pop_data    <= mem[rd_ptr];
        pop_channel <= rd_ptr[2:0];
        rd_ptr      <= rd_ptr + 1'b1;
      end
      count           <= count_nxt;
      empty           <= (count_nxt == '0);
      full            <= (count_nxt == FULL_CNT);
      frame_available <= (count_nxt[AW:3] != '0);
    end
  end

`ifdef THRESHOLD_SAMPLE_FIFO_FRAME_COUNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_count <= '0;
      high_water  <= '0;
    end else if (clr) begin
      frame_count <= '0;
      high_water  <= '0;
    end else begin
      frame_count <= count_nxt[AW:3];
      if (count_nxt[AW:3] > high_water) high_water <= count_nxt[AW:3];
    end
  end
`endif
endmodule
